// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC control sequencer for the 8-bit CISC core, with
// run/single-step debug control, a sticky HALT state and a retired-instruction counter.
module cpu_sequencer #(
  parameter int                          OP_WIDTH        = 4,
  parameter int                          ADDR_MODE_WIDTH = 2,
  parameter int                          CNT_WIDTH       = 16,
  parameter logic [OP_WIDTH-1:0]         OP_STORE        = 4'hA,
  parameter logic [OP_WIDTH-1:0]         OP_JMP          = 4'hB,
  parameter logic [OP_WIDTH-1:0]         OP_JZ           = 4'hC,
  parameter logic [OP_WIDTH-1:0]         OP_JN           = 4'hD,
  parameter logic [OP_WIDTH-1:0]         OP_NOP          = 4'hE,
  parameter logic [OP_WIDTH-1:0]         OP_HALT         = 4'hF,
  parameter logic [ADDR_MODE_WIDTH-1:0]  MODE_REG        = 2'b10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       step,
  input  logic [OP_WIDTH-1:0]        opcode,
  input  logic [ADDR_MODE_WIDTH-1:0] addr_mode,
  input  logic                       zero_flag,
  input  logic                       sign_flag,
  output logic                       fetch_ena,
  output logic                       execute_ena,
  output logic                       write_ram_ena,
  output logic                       write_reg_ena,
  output logic                       jump_ena,
  output logic                       busy,
  output logic                       halted,
  output logic [CNT_WIDTH-1:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t               state_reg, state_next;
  logic                 step_latch_reg, step_latch_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      step_latch_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      step_latch_reg <= step_latch_next;
      count_reg      <= count_next;
    end
  end

  // Strobes come from the registered state only, so reset clears them without a clock.
  always_comb begin
    state_next      = state_reg;
    step_latch_next = step_latch_reg;
    count_next      = count_reg;
    fetch_ena       = 1'b0;
    execute_ena     = 1'b0;
    write_ram_ena   = 1'b0;
    write_reg_ena   = 1'b0;
    jump_ena        = 1'b0;
    busy            = 1'b0;
    halted          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run || step) begin
          state_next      = S_FETCH;
          step_latch_next = !run;
        end
      end

      S_FETCH: begin
        busy       = 1'b1;
        fetch_ena  = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        busy       = 1'b1;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        busy = 1'b1;
        case (opcode)
          OP_STORE: begin
            if (addr_mode == MODE_REG) write_reg_ena = 1'b1;
            else                       write_ram_ena = 1'b1;
          end
          OP_JMP:  jump_ena = 1'b1;
          OP_JZ:   jump_ena = zero_flag;
          OP_JN:   jump_ena = sign_flag;
          OP_NOP:  ;
          OP_HALT: ;
          default: execute_ena = 1'b1;
        endcase

        step_latch_next = 1'b0;
        if (opcode == OP_HALT) begin
          state_next = S_HALTED;
        end else begin
          count_next = count_reg + CNT_WIDTH'(1);
          state_next = (run && !step_latch_reg) ? S_FETCH : S_IDLE;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign instr_count = count_reg;

endmodule
